ex_mem_pipe: RTL and testbench

- Parametrised EX→MEM pipeline register; the next generation of the plain EX/MEM latch.
- Adds a valid/ready handshake, a 2-entry skid buffer (registered ready), a synchronous flush, and PC carry-through.
- Sits between the execute stage and the memory stage of the 5-stage MIPS core.
- With a macro enabled, also carries the HI/LO write-back.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/pipe_skid_slot.sv | 27 ++
 rtl/ex_mem_pipe.sv | 154 +++++++++++++++
 tb/tb_ex_mem_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the EX/MEM pipeline register: occupancy encoding, defaults, payload.
// Optional HI/LO write-back fields are present when EX_MEM_HILO_EN is defined.
package cpu_pkg;

    localparam int unsigned CpuDataW = 32;
    localparam int unsigned CpuRegAw = 5;
    localparam int unsigned CpuPcW   = 32;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StFull  = 2'b01,
        StSkid  = 2'b10
    } occ_e;

    localparam logic [CpuRegAw-1:0] NopRegAddr = '0;
    localparam logic [CpuDataW-1:0] ZeroWord   = '0;

    // Core-width payload layout; ex_mem_pipe mirrors this at its parameter widths.
    typedef struct packed {
`ifdef EX_MEM_HILO_EN
        logic                whilo;
        logic [CpuDataW-1:0] hi;
        logic [CpuDataW-1:0] lo;
`endif
        logic [CpuRegAw-1:0] wd;
        logic                wreg;
        logic [CpuDataW-1:0] wdata;
        logic [CpuPcW-1:0]   pc;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload storage slot: async active-low reset, synchronous clear, load enable.
module pipe_skid_slot #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] slot_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
        end else if (clr_i) begin
            slot_q <= '0;
        end else if (load_i) begin
            slot_q <= d_i;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshake, 2-entry skid buffer and sync flush.
// Define EX_MEM_HILO_EN to also carry the HI/LO write-back.
module ex_mem_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [REG_AW-1:0] ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [PC_W-1:0]   ex_pc,
`ifdef EX_MEM_HILO_EN
    input  logic              ex_whilo,
    input  logic [DATA_W-1:0] ex_hi,
    input  logic [DATA_W-1:0] ex_lo,
    output logic              mem_whilo,
    output logic [DATA_W-1:0] mem_hi,
    output logic [DATA_W-1:0] mem_lo,
`endif
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [REG_AW-1:0] mem_wd,
    output logic              mem_wreg,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [PC_W-1:0]   mem_pc
);

    typedef struct packed {
`ifdef EX_MEM_HILO_EN
        logic              whilo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
`endif
        logic [REG_AW-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [PC_W-1:0]   pc;
    } payload_t;

    occ_e     state_q, state_d;
    logic     ex_ready_q, ex_ready_d;
    logic     in_xfer, out_xfer;
    logic     main_load, main_from_skid, skid_load;
    payload_t ex_payload, main_d, main_q, skid_q;

    always_comb begin
        ex_payload       = '0;
        ex_payload.wd    = ex_wd;
        ex_payload.wreg  = ex_wreg;
        ex_payload.wdata = ex_wdata;
        ex_payload.pc    = ex_pc;
`ifdef EX_MEM_HILO_EN
        ex_payload.whilo = ex_whilo;
        ex_payload.hi    = ex_hi;
        ex_payload.lo    = ex_lo;
`endif
    end

    assign mem_valid = (state_q != StEmpty);
    assign in_xfer   = ex_valid & ex_ready_q;
    assign out_xfer  = mem_valid & mem_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d   = StFull;
                        main_load = 1'b1;
                    end
                end
                StFull: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = StSkid;
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StSkid: begin
                    if (out_xfer) begin
                        state_d        = StFull;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        // Ready is a flop: derived from next occupancy, never from mem_ready directly.
        ex_ready_d = (state_d != StSkid);
    end

    assign main_d = main_from_skid ? skid_q : ex_payload;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEmpty;
            ex_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ex_ready_q <= ex_ready_d;
        end
    end

    pipe_skid_slot #(
        .Width($bits(payload_t))
    ) u_main_slot (
        .clk_i (clk),
        .rst_ni(rst),
        .clr_i (flush),
        .load_i(main_load),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_skid_slot #(
        .Width($bits(payload_t))
    ) u_skid_slot (
        .clk_i (clk),
        .rst_ni(rst),
        .clr_i (flush),
        .load_i(skid_load),
        .d_i   (ex_payload),
        .q_o   (skid_q)
    );

    assign ex_ready  = ex_ready_q;
    assign mem_wd    = main_q.wd;
    assign mem_wreg  = main_q.wreg & mem_valid;
    assign mem_wdata = main_q.wdata;
    assign mem_pc    = main_q.pc;
`ifdef EX_MEM_HILO_EN
    assign mem_whilo = main_q.whilo & mem_valid;
    assign mem_hi    = main_q.hi;
    assign mem_lo    = main_q.lo;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: streaming, skid stall, flush, bubbles, async reset, HI/LO.
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_pc;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
`ifdef EX_MEM_HILO_EN
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ex_mem_pipe #(
        .DATA_W(32),
        .REG_AW(5),
        .PC_W  (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_wd    (ex_wd),
        .ex_wreg  (ex_wreg),
        .ex_wdata (ex_wdata),
        .ex_pc    (ex_pc),
`ifdef EX_MEM_HILO_EN
        .ex_whilo (ex_whilo),
        .ex_hi    (ex_hi),
        .ex_lo    (ex_lo),
        .mem_whilo(mem_whilo),
        .mem_hi   (mem_hi),
        .mem_lo   (mem_lo),
`endif
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_wd   (mem_wd),
        .mem_wreg (mem_wreg),
        .mem_wdata(mem_wdata),
        .mem_pc   (mem_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] wd, input logic [31:0] wdata, input logic [31:0] pc);
        ex_valid = 1'b1;
        ex_wd    = wd;
        ex_wreg  = 1'b1;
        ex_wdata = wdata;
        ex_pc    = pc;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        ex_valid  = 1'b0;
        ex_wd     = '0;
        ex_wreg   = 1'b0;
        ex_wdata  = '0;
        ex_pc     = '0;
        mem_ready = 1'b0;
`ifdef EX_MEM_HILO_EN
        ex_whilo  = 1'b0;
        ex_hi     = '0;
        ex_lo     = '0;
`endif

        // Reset held for two cycles
        step();
        step();
        chk("rst_valid", mem_valid, 0);
        chk("rst_ready", ex_ready, 1);
        chk("rst_wd", mem_wd, 0);
        chk("rst_wreg", mem_wreg, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pc", mem_pc, 0);
`ifdef EX_MEM_HILO_EN
        chk("rst_whilo", mem_whilo, 0);
`endif
        rst = 1'b1;

        // Streaming: one entry per cycle, one cycle latency
        mem_ready = 1'b1;
        send(5'd5, 32'h11, 32'h100);
        step();
        chk("str0_valid", mem_valid, 1);
        chk("str0_wd", mem_wd, 5);
        chk("str0_wdata", mem_wdata, 32'h11);
        chk("str0_pc", mem_pc, 32'h100);
        chk("str0_wreg", mem_wreg, 1);
        send(5'd6, 32'h22, 32'h104);
        step();
        chk("str1_valid", mem_valid, 1);
        chk("str1_wd", mem_wd, 6);
        chk("str1_wdata", mem_wdata, 32'h22);
        send(5'd7, 32'h33, 32'h108);
        step();
        chk("str2_valid", mem_valid, 1);
        chk("str2_wd", mem_wd, 7);
        chk("str2_pc", mem_pc, 32'h108);
        ex_valid = 1'b0;
        step();
        chk("str_drain_valid", mem_valid, 0);

        // Stall into skid
        mem_ready = 1'b0;
        send(5'd1, 32'hA, 32'h200);
        step();
        chk("stall_a_valid", mem_valid, 1);
        chk("stall_a_wdata", mem_wdata, 32'hA);
        chk("stall_a_ready", ex_ready, 1);
        send(5'd2, 32'hB, 32'h204);
        step();
        chk("skid_ready", ex_ready, 0);
        chk("skid_wdata", mem_wdata, 32'hA);
        chk("skid_wd", mem_wd, 1);
        send(5'd3, 32'hC, 32'h208);
        step();
        chk("skid_hold_wdata", mem_wdata, 32'hA);
        chk("skid_hold_pc", mem_pc, 32'h200);
        chk("skid_hold_ready", ex_ready, 0);
        ex_valid  = 1'b0;
        mem_ready = 1'b1;
        step();
        chk("drain_b_wdata", mem_wdata, 32'hB);
        chk("drain_b_wd", mem_wd, 2);
        chk("drain_b_ready", ex_ready, 1);
        chk("drain_b_valid", mem_valid, 1);
        step();
        chk("drain_empty", mem_valid, 0);

        // Flush in SKID with a concurrent input
        mem_ready = 1'b0;
        send(5'd8, 32'hD, 32'h300);
        step();
        send(5'd9, 32'hE, 32'h304);
        step();
        chk("fl_pre_ready", ex_ready, 0);
        flush = 1'b1;
        send(5'd10, 32'hF, 32'h308);
        step();
        chk("fl_valid", mem_valid, 0);
        chk("fl_wreg", mem_wreg, 0);
        chk("fl_ready", ex_ready, 1);
        chk("fl_wdata", mem_wdata, 0);
        flush     = 1'b0;
        ex_valid  = 1'b0;
        mem_ready = 1'b1;
        step();
        chk("fl_dropped", mem_valid, 0);

        // Bubbles never raise mem_wreg
        ex_wreg = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bub_valid", mem_valid, 0);
            chk("bub_wreg", mem_wreg, 0);
        end

        // Asynchronous reset while in SKID
        mem_ready = 1'b0;
        send(5'd12, 32'h55, 32'h400);
        step();
        send(5'd13, 32'h66, 32'h404);
        step();
        ex_valid = 1'b0;
        chk("ar_pre_ready", ex_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", mem_valid, 0);
        chk("ar_ready", ex_ready, 1);
        chk("ar_wdata", mem_wdata, 0);
        chk("ar_wd", mem_wd, 0);
        chk("ar_pc", mem_pc, 0);
        step();
        rst       = 1'b1;
        mem_ready = 1'b1;
        send(5'd31, 32'hFFFF_FFFF, 32'h500);
        step();
        chk("ar_new_valid", mem_valid, 1);
        chk("ar_new_wd", mem_wd, 31);
        chk("ar_new_wdata", mem_wdata, 32'hFFFF_FFFF);
        chk("ar_new_pc", mem_pc, 32'h500);
        ex_valid = 1'b0;
        step();
        chk("ar_new_drain", mem_valid, 0);

`ifdef EX_MEM_HILO_EN
        // HI/LO carried through a one-cycle stall
        mem_ready = 1'b0;
        send(5'd4, 32'h77, 32'h600);
        ex_whilo = 1'b1;
        ex_hi    = 32'h1234;
        ex_lo    = 32'h5678;
        step();
        ex_valid = 1'b0;
        ex_whilo = 1'b0;
        ex_hi    = 32'h0;
        ex_lo    = 32'h0;
        chk("hl_whilo", mem_whilo, 1);
        chk("hl_hi", mem_hi, 32'h1234);
        chk("hl_lo", mem_lo, 32'h5678);
        mem_ready = 1'b1;
        step();
        chk("hl_drain_whilo", mem_whilo, 0);
        chk("hl_drain_valid", mem_valid, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
